// File: rtl/axis_timed_replay.sv
// Replays queued BEAT / DELAY / WAIT_ABS / TS_LOAD commands onto an AXI-Stream master port.
// Optional beat/packet counters are enabled with `define AXIS_TIMED_REPLAY_STATS_EN.
module axis_timed_replay #(
  parameter int unsigned W_DATA = 512,
  parameter int unsigned W_KEEP = W_DATA / 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned W_TIME = 32
) (
  input  logic                       axis_aclk,
  input  logic                       axis_aresetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_type,
  input  logic [W_TIME-1:0]          cmd_time,
  input  logic [W_DATA-1:0]          cmd_data,
  input  logic [W_KEEP-1:0]          cmd_keep,
  input  logic                       cmd_last,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [W_DATA-1:0]          m_axis_tdata,
  output logic [W_KEEP-1:0]          m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic [W_TIME-1:0]          timestamp,
  output logic [$clog2(DEPTH):0]     cmd_count,
  output logic                       busy,
  output logic                       late
`ifdef AXIS_TIMED_REPLAY_STATS_EN
  ,
  output logic [31:0]                beat_count,
  output logic [31:0]                pkt_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    CmdBeat    = 2'd0,
    CmdDelay   = 2'd1,
    CmdWaitAbs = 2'd2,
    CmdTsLoad  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    StIdle,
    StDly,
    StWait
  } state_e;

  // Command FIFO storage (no reset needed; validity is tracked by the pointers).
  cmd_e              fifo_type [DEPTH];
  logic [W_TIME-1:0] fifo_time [DEPTH];
  logic [W_DATA-1:0] fifo_data [DEPTH];
  logic [W_KEEP-1:0] fifo_keep [DEPTH];
  logic              fifo_last [DEPTH];

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              cmd_ready_q;

  state_e            state_q, state_d;
  logic [W_TIME-1:0] dly_q, dly_d;
  logic [W_TIME-1:0] target_q, target_d;
  logic [W_TIME-1:0] ts_q, ts_d;
  logic              late_q, late_d;

  logic              tvalid_q, tvalid_d;
  logic [W_DATA-1:0] tdata_q, tdata_d;
  logic [W_KEEP-1:0] tkeep_q, tkeep_d;
  logic              tlast_q, tlast_d;

  logic              push, pop, empty, out_free, load_beat;
  logic              head_reached, target_reached;
  cmd_e              head_type;
  logic [W_TIME-1:0] head_time;

  assign empty     = (count_q == '0);
  assign push      = cmd_valid & cmd_ready_q;
  assign out_free  = ~tvalid_q | m_axis_tready;
  assign pop       = ~empty & (state_q == StIdle) & out_free;
  assign head_type = fifo_type[rd_ptr_q];
  assign head_time = fifo_time[rd_ptr_q];

  // Signed difference keeps absolute waits correct across timestamp wrap.
  assign head_reached   = $signed(ts_q - head_time) >= $signed({W_TIME{1'b0}});
  assign target_reached = $signed(ts_q - target_q) >= $signed({W_TIME{1'b0}});

  always_ff @(posedge axis_aclk) begin
    if (push) begin
      fifo_type[wr_ptr_q] <= cmd_e'(cmd_type);
      fifo_time[wr_ptr_q] <= cmd_time;
      fifo_data[wr_ptr_q] <= cmd_data;
      fifo_keep[wr_ptr_q] <= cmd_keep;
      fifo_last[wr_ptr_q] <= cmd_last;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ts_d = ts_q + W_TIME'(1);
    if (pop && head_type == CmdTsLoad) begin
      ts_d = head_time;
    end
  end

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    target_d  = target_q;
    late_d    = 1'b0;
    load_beat = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          unique case (head_type)
            CmdBeat: load_beat = 1'b1;
            CmdDelay: begin
              // The pop cycle itself counts as one cycle of the delay.
              if (head_time != '0) begin
                dly_d   = head_time - W_TIME'(1);
                state_d = StDly;
              end
            end
            CmdWaitAbs: begin
              if (head_reached) begin
                late_d = 1'b1;
              end else begin
                target_d = head_time;
                state_d  = StWait;
              end
            end
            CmdTsLoad: ;
          endcase
        end
      end
      StDly: begin
        if (dly_q == '0) begin
          state_d = StIdle;
        end else begin
          dly_d = dly_q - W_TIME'(1);
        end
      end
      StWait: begin
        if (target_reached) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    if (load_beat) begin
      tvalid_d = 1'b1;
      tdata_d  = fifo_data[rd_ptr_q];
      tkeep_d  = fifo_keep[rd_ptr_q];
      tlast_d  = fifo_last[rd_ptr_q];
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      state_q     <= StIdle;
      dly_q       <= '0;
      target_q    <= '0;
      ts_q        <= '0;
      late_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      cmd_ready_q <= (count_d < CW'(DEPTH));
      state_q     <= state_d;
      dly_q       <= dly_d;
      target_q    <= target_d;
      ts_q        <= ts_d;
      late_q      <= late_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign timestamp     = ts_q;
  assign cmd_count     = count_q;
  assign late          = late_q;
  assign busy          = ~empty | (state_q != StIdle) | tvalid_q;

`ifdef AXIS_TIMED_REPLAY_STATS_EN
  logic        hs;
  logic [31:0] beat_count_q, pkt_count_q;

  assign hs = tvalid_q & m_axis_tready;

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      beat_count_q <= '0;
      pkt_count_q  <= '0;
    end else begin
      if (hs && beat_count_q != '1) beat_count_q <= beat_count_q + 32'd1;
      if (hs && tlast_q && pkt_count_q != '1) pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  assign beat_count = beat_count_q;
  assign pkt_count  = pkt_count_q;
`endif

endmodule

// File: tb/tb_axis_timed_replay.sv
// Directed bench for axis_timed_replay: beats, delays, absolute waits, wrap, backpressure, reset.
module tb_axis_timed_replay;
  localparam int unsigned W_DATA = 64;
  localparam int unsigned W_KEEP = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned W_TIME = 32;

  logic              clk = 1'b0;
  logic              aresetn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_type;
  logic [W_TIME-1:0] cmd_time;
  logic [W_DATA-1:0] cmd_data;
  logic [W_KEEP-1:0] cmd_keep;
  logic              cmd_last;
  logic              m_tvalid;
  logic              m_tready;
  logic [W_DATA-1:0] m_tdata;
  logic [W_KEEP-1:0] m_tkeep;
  logic              m_tlast;
  logic [W_TIME-1:0] ts;
  logic [2:0]        cmd_count;
  logic              busy;
  logic              late;
`ifdef AXIS_TIMED_REPLAY_STATS_EN
  logic [31:0]       beat_count;
  logic [31:0]       pkt_count;
`endif

  always #5 clk = ~clk;

  axis_timed_replay #(
    .W_DATA(W_DATA),
    .W_KEEP(W_KEEP),
    .DEPTH (DEPTH),
    .W_TIME(W_TIME)
  ) dut (
    .axis_aclk    (clk),
    .axis_aresetn (aresetn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_type     (cmd_type),
    .cmd_time     (cmd_time),
    .cmd_data     (cmd_data),
    .cmd_keep     (cmd_keep),
    .cmd_last     (cmd_last),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tlast (m_tlast),
    .timestamp    (ts),
    .cmd_count    (cmd_count),
    .busy         (busy),
    .late         (late)
`ifdef AXIS_TIMED_REPLAY_STATS_EN
    ,
    .beat_count   (beat_count),
    .pkt_count    (pkt_count)
`endif
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [31:0] ts;
    int          cyc;
    logic        busy;
  } hs_t;

  hs_t hs[$];
  int  cyc      = 0;
  int  late_cnt = 0;
  int  n_vec    = 0;
  int  n_bad    = 0;

  // Handshake capture: values seen at the edge where the beat transfers.
  always @(posedge clk) begin
    if (aresetn && m_tvalid && m_tready) begin
      hs.push_back('{data: m_tdata, last: m_tlast, ts: ts, cyc: cyc, busy: busy});
    end
    if (aresetn && late) late_cnt <= late_cnt + 1;
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] ty, input logic [31:0] tm, input logic [63:0] d,
                      input logic l, output int acc);
    int g;
    cmd_valid = 1'b1;
    cmd_type  = ty;
    cmd_time  = tm;
    cmd_data  = d;
    cmd_keep  = '1;
    cmd_last  = l;
    g = 0;
    while (!cmd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!cmd_ready) chk("push_ready", {63'd0, cmd_ready}, 64'd1);
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_hs(input string tag, input int n);
    int g;
    g = 0;
    while (hs.size() < n && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk(tag, 64'(hs.size()), 64'(n));
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, a1, aw, l0;
    aresetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_type  = '0;
    cmd_time  = '0;
    cmd_data  = '0;
    cmd_keep  = '0;
    cmd_last  = 1'b0;
    m_tready  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_tdata", m_tdata, 64'd0);
    chk("rst_count", 64'(cmd_count), 64'd0);
    chk("rst_ts", 64'(ts), 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_late", {63'd0, late}, 64'd0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("ts_inc1", 64'(ts), 64'd1);
    @(negedge clk);
    chk("ts_inc2", 64'(ts), 64'd2);
    chk("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

    // Four back-to-back beats
    m_tready = 1'b1;
    hs.delete();
    push(2'd0, 0, 64'h1, 1'b0, a0);
    push(2'd0, 0, 64'h2, 1'b0, a1);
    push(2'd0, 0, 64'h3, 1'b0, a1);
    push(2'd0, 0, 64'h4, 1'b1, a1);
    wait_hs("burst_hs", 4);
    chk("burst_busy_fall", {63'd0, busy}, 64'd0);
    if (hs.size() == 4) begin
      chk("burst_latency", 64'(hs[0].cyc), 64'(a0 + 2));
      for (int i = 0; i < 4; i++) begin
        chk("burst_data", hs[i].data, 64'(i + 1));
        chk("burst_last", {63'd0, hs[i].last}, (i == 3) ? 64'd1 : 64'd0);
        chk("burst_cycle", 64'(hs[i].cyc), 64'(hs[0].cyc + i));
        chk("burst_busy", {63'd0, hs[i].busy}, 64'd1);
      end
    end

    // DELAY 5 between two beats
    wait_idle();
    hs.delete();
    push(2'd0, 0, 64'hA, 1'b1, a0);
    push(2'd1, 5, 64'h0, 1'b0, a1);
    push(2'd0, 0, 64'hB, 1'b1, a1);
    wait_hs("dly5_hs", 2);
    if (hs.size() == 2) begin
      chk("dly5_gap", 64'(hs[1].cyc - hs[0].cyc), 64'd7);
      chk("dly5_data", hs[1].data, 64'hB);
    end

    // DELAY 0 costs one extra cycle
    wait_idle();
    hs.delete();
    push(2'd0, 0, 64'hA, 1'b1, a0);
    push(2'd1, 0, 64'h0, 1'b0, a1);
    push(2'd0, 0, 64'hB, 1'b1, a1);
    wait_hs("dly0_hs", 2);
    if (hs.size() == 2) chk("dly0_gap", 64'(hs[1].cyc - hs[0].cyc), 64'd2);

    // TS_LOAD 100, WAIT_ABS 150, BEAT
    wait_idle();
    l0 = late_cnt;
    hs.delete();
    push(2'd3, 100, 64'h0, 1'b0, a0);
    push(2'd2, 150, 64'h0, 1'b0, a1);
    push(2'd0, 0, 64'hC, 1'b1, a1);
    wait_hs("wait_hs", 1);
    if (hs.size() == 1) chk("wait_ts", 64'(hs[0].ts), 64'd152);
    chk("wait_no_late", 64'(late_cnt), 64'(l0));

    // WAIT_ABS in the past: late pulse, no stall
    wait_idle();
    hs.delete();
    push(2'd2, 120, 64'h0, 1'b0, aw);
    push(2'd0, 0, 64'hD, 1'b1, a1);
    wait_hs("past_hs", 1);
    if (hs.size() == 1) chk("past_nostall", 64'(hs[0].cyc), 64'(aw + 3));
    repeat (2) @(negedge clk);
    chk("past_late_once", 64'(late_cnt), 64'(l0 + 1));

    // Wait spanning timestamp wrap
    wait_idle();
    hs.delete();
    push(2'd3, 32'hFFFF_FFF0, 64'h0, 1'b0, a0);
    push(2'd2, 32'h0000_0005, 64'h0, 1'b0, a1);
    push(2'd0, 0, 64'hE, 1'b1, a1);
    wait_hs("wrap_hs", 1);
    if (hs.size() == 1) chk("wrap_ts", 64'(hs[0].ts), 64'd7);
    chk("wrap_no_late", 64'(late_cnt), 64'(l0 + 1));

    // Backpressure fills the FIFO
    wait_idle();
    m_tready = 1'b0;
    hs.delete();
    for (int i = 0; i <= DEPTH; i++) begin
      push(2'd0, 0, 64'(32'h10 + i), (i == DEPTH), a1);
    end
    chk("full_count", 64'(cmd_count), 64'(DEPTH));
    chk("full_ready", {63'd0, cmd_ready}, 64'd0);
    chk("full_tvalid", {63'd0, m_tvalid}, 64'd1);
    chk("full_tdata", m_tdata, 64'h10);
    cmd_valid = 1'b1;
    cmd_type  = 2'd0;
    cmd_data  = 64'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_hold_count", 64'(cmd_count), 64'(DEPTH));
      chk("full_hold_tdata", m_tdata, 64'h10);
      chk("full_hold_tvalid", {63'd0, m_tvalid}, 64'd1);
    end
    cmd_valid = 1'b0;
    m_tready  = 1'b1;
    wait_hs("drain_hs", DEPTH + 1);
    if (hs.size() == DEPTH + 1) begin
      for (int i = 0; i <= DEPTH; i++) begin
        chk("drain_data", hs[i].data, 64'(32'h10 + i));
        chk("drain_last", {63'd0, hs[i].last}, (i == DEPTH) ? 64'd1 : 64'd0);
      end
    end

    // Reset mid-packet
    wait_idle();
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(2'd0, 0, 64'(32'h20 + i), 1'b0, a1);
    end
    chk("pre_rst_count", 64'(cmd_count), 64'd3);
    aresetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("mid_rst_count", 64'(cmd_count), 64'd0);
    chk("mid_rst_ts", 64'(ts), 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
`ifdef AXIS_TIMED_REPLAY_STATS_EN
    chk("mid_rst_beats", 64'(beat_count), 64'd0);
`endif
    aresetn  = 1'b1;
    hs.delete();
    m_tready = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_no_beats", 64'(hs.size()), 64'd0);
    chk("post_rst_ts", 64'(ts), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
